// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_pkg
// Purpose  : Shared constants and state encoding for the serial ADC responder
// Revision : 1.0 - initial release
// ============================================================================
package adc_pkg;

  localparam int ADC_DW          = 10;  // sample width returned per frame
  localparam int CFG_BITS        = 4;   // SGL, D2, D1, D0
  localparam int NUM_CH          = 8;   // channels behind the mux
  localparam int DEF_LEAD_CYCLES = 2;   // quiet posedges before first data bit

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFG   = 2'd1,
    ST_LEAD  = 2'd2,
    ST_SHIFT = 2'd3
  } adc_state_e;

endpackage
`default_nettype wire

// File: rtl/adc_sample_mux.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_mux
// Purpose  : Channel select plus clipped differential subtract
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_mux
  import adc_pkg::*;
#(
  parameter int DW = ADC_DW
) (
  input  logic                 sgl_i,
  input  logic [2:0]           ch_i,
  input  logic [NUM_CH*DW-1:0] ch_data_i,
  output logic [DW-1:0]        value_o
);

  logic [DW-1:0] pos_w;
  logic [DW-1:0] neg_w;
  logic [DW:0]   diff_w;

  // IN+ is always the addressed channel; IN- is its pair partner (index ^ 1),
  // which covers both D0 polarities of a differential pair.
  always_comb begin
    pos_w   = ch_data_i[int'(ch_i) * DW +: DW];
    neg_w   = ch_data_i[int'(ch_i ^ 3'd1) * DW +: DW];
    diff_w  = {1'b0, pos_w} - {1'b0, neg_w};
    value_o = pos_w;
    if (!sgl_i) begin
      // A borrow out of the extended subtract means IN+ < IN-: clip to zero.
      value_o = diff_w[DW] ? '0 : diff_w[DW-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_serial_responder.sv
`default_nettype none
// ============================================================================
// Module   : adc_serial_responder
// Purpose  : Device side of the 3-wire serial ADC link. Decodes start + 4
//            config bits on din, freezes the selected sample, and returns it
//            MSB first on dout. All logic on posedge; controller uses negedge.
// Revision : 1.0 - initial release
// ============================================================================
module adc_serial_responder
  import adc_pkg::*;
#(
  parameter int DW          = ADC_DW,
  parameter int LEAD_CYCLES = DEF_LEAD_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 conv,
  input  logic [NUM_CH*DW-1:0] ch_data,
  output logic                 dout,
  output logic                 busy,
  output logic                 cfg_valid,
  output logic                 cfg_sgl,
  output logic [2:0]           cfg_ch,
  output logic                 frame_err
);

  // cnt_q holds the number of posedges since the start bit, so during the
  // frame the edge at S+k sees cnt_q == k.
  localparam int             CW            = $clog2(DW + LEAD_CYCLES + 5);
  localparam logic [CW-1:0]  C_CFG_END     = CW'(CFG_BITS);
  localparam logic [CW-1:0]  C_LEAD_END    = CW'(CFG_BITS + LEAD_CYCLES);
  localparam logic [CW-1:0]  C_SHIFT_END   = CW'(CFG_BITS + 1 + LEAD_CYCLES + DW);

  adc_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     cfg_sr_q, cfg_sr_d;
  logic [DW-1:0]  hold_q, hold_d;
  logic           abort_pend_q, abort_pend_d;
  logic           dout_q, dout_d;
  logic           busy_q, busy_d;
  logic           cfg_valid_q, cfg_valid_d;
  logic           cfg_sgl_q, cfg_sgl_d;
  logic [2:0]     cfg_ch_q, cfg_ch_d;
  logic           frame_err_q, frame_err_d;

  logic           mux_sgl_w;
  logic [2:0]     mux_ch_w;
  logic [DW-1:0]  mux_value_w;

  // The final config bit is still on din at S+4, so the mux sees the
  // complete command one edge before it lands in cfg_*.
  assign mux_sgl_w = cfg_sr_q[2];
  assign mux_ch_w  = {cfg_sr_q[1:0], din};

  adc_sample_mux #(
    .DW (DW)
  ) u_mux (
    .sgl_i     (mux_sgl_w),
    .ch_i      (mux_ch_w),
    .ch_data_i (ch_data),
    .value_o   (mux_value_w)
  );

  // Next-state logic for the frame FSM and its datapath.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cfg_sr_d     = cfg_sr_q;
    hold_d       = hold_q;
    dout_d       = 1'b0;
    busy_d       = busy_q;
    cfg_valid_d  = 1'b0;
    cfg_sgl_d    = cfg_sgl_q;
    cfg_ch_d     = cfg_ch_q;
    frame_err_d  = 1'b0;
    // Abort is acted on one edge after conv is seen outside IDLE.
    abort_pend_d = conv && (state_q != ST_IDLE) && !abort_pend_q;

    if (abort_pend_q) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      busy_d      = 1'b0;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (din && !conv) begin
            state_d = ST_CFG;
            cnt_d   = CW'(1);
            busy_d  = 1'b1;
          end
        end
        ST_CFG: begin
          cnt_d    = cnt_q + CW'(1);
          cfg_sr_d = {cfg_sr_q[1:0], din};
          if (cnt_q == C_CFG_END) begin
            cfg_sgl_d   = mux_sgl_w;
            cfg_ch_d    = mux_ch_w;
            cfg_valid_d = 1'b1;
            hold_d      = mux_value_w;
            state_d     = (LEAD_CYCLES == 0) ? ST_SHIFT : ST_LEAD;
          end
        end
        ST_LEAD: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == C_LEAD_END) begin
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == C_SHIFT_END) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            dout_d = hold_q[DW-1];
            hold_d = {hold_q[DW-2:0], 1'b0};
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cfg_sr_q     <= '0;
      hold_q       <= '0;
      abort_pend_q <= 1'b0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      cfg_valid_q  <= 1'b0;
      cfg_sgl_q    <= 1'b0;
      cfg_ch_q     <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_sr_q     <= cfg_sr_d;
      hold_q       <= hold_d;
      abort_pend_q <= abort_pend_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_sgl_q    <= cfg_sgl_d;
      cfg_ch_q     <= cfg_ch_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_sgl   = cfg_sgl_q;
  assign cfg_ch    = cfg_ch_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_serial_responder
// Purpose  : Directed bench acting as the negedge sampling controller
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_serial_responder;

  localparam int DW = 10;

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic            din     = 1'b0;
  logic            conv    = 1'b0;
  logic [8*DW-1:0] ch_data = '0;
  logic            dout;
  logic            busy;
  logic            cfg_valid;
  logic            cfg_sgl;
  logic [2:0]      cfg_ch;
  logic            frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  adc_serial_responder #(
    .DW          (DW),
    .LEAD_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .conv      (conv),
    .ch_data   (ch_data),
    .dout      (dout),
    .busy      (busy),
    .cfg_valid (cfg_valid),
    .cfg_sgl   (cfg_sgl),
    .cfg_ch    (cfg_ch),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    ch_data[k*DW +: DW] = v;
  endtask

  // One controller frame. Iteration k drives inputs for posedge S+k and
  // checks the outputs on the following negedge.
  task automatic run_frame(input string tag, input logic sgl, input logic [2:0] ch,
                           input logic [DW-1:0] exp, input int abort_k,
                           input int chg_k, input int chg_ch, input logic [DW-1:0] chg_val,
                           input int rst_k, input bit gap);
    logic [DW-1:0] word;
    logic [4:0]    cmd;
    bit            ferr_seen;
    word      = '0;
    cmd       = {1'b1, sgl, ch};
    ferr_seen = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      din  = (k <= 4) ? cmd[4-k] : 1'b0;
      conv = (k == abort_k);
      if (k == chg_k) set_ch(chg_ch, chg_val);
      @(negedge clk);
      if (k == rst_k) begin
        chk({tag, " pre_rst_dout"}, 32'(dout), 32'(1));
        rst_n = 1'b0;
        #1;
        chk({tag, " rst_outs"}, 32'({dout, busy, cfg_valid, cfg_sgl, cfg_ch, frame_err}), 32'(0));
        din = 1'b0;
        return;
      end
      if (abort_k >= 0 && k == abort_k + 1) begin
        chk({tag, " abort_outs"}, 32'({dout, busy, frame_err}), 32'(3'b001));
        conv = 1'b0;
        @(negedge clk);
        chk({tag, " abort_pulse_end"}, 32'({busy, frame_err}), 32'(0));
        return;
      end
      if (frame_err) ferr_seen = 1'b1;
      if (k == 0)  chk({tag, " busy_rise"}, 32'(busy), 32'(1));
      if (k == 4)  chk({tag, " cfg"}, 32'({cfg_valid, cfg_sgl, cfg_ch}), 32'({1'b1, sgl, ch}));
      if (k == 5)  chk({tag, " cfg_valid_pulse"}, 32'(cfg_valid), 32'(0));
      if (k == 6)  chk({tag, " lead_dout"}, 32'(dout), 32'(0));
      if (k >= 7 && k <= 16) word[16-k] = dout;
      if (k == 16) chk({tag, " busy_last_bit"}, 32'(busy), 32'(1));
      if (k == 17) begin
        chk({tag, " busy_fall"}, 32'({busy, dout}), 32'(0));
        chk({tag, " word"}, 32'(word), 32'(exp));
      end
    end
    din  = 1'b0;
    conv = 1'b0;
    chk({tag, " no_frame_err"}, 32'(ferr_seen), 32'(0));
    if (gap) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({dout, busy, cfg_valid, cfg_sgl, cfg_ch, frame_err}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: async reset mid-SHIFT (S+7 carries bit 9 = 1 of 0x2A5)
    set_ch(2, 10'h2A5);
    run_frame("t1", 1'b1, 3'd2, 10'h2A5, -1, -1, 0, '0, 7, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1 idle_busy", 32'(busy), 32'(0));
    end

    // 2: single-ended ch2, followed immediately by a start at S+18
    run_frame("t2a", 1'b1, 3'd2, 10'h2A5, -1, -1, 0, '0, -1, 1'b0);
    run_frame("t2b", 1'b1, 3'd2, 10'h2A5, -1, -1, 0, '0, -1, 1'b1);

    // 3: differential pair 0 and clipping, plus single-ended ch1
    set_ch(0, 10'd300);
    set_ch(1, 10'd100);
    run_frame("t3_diff0", 1'b0, 3'd0, 10'd200, -1, -1, 0, '0, -1, 1'b1);
    run_frame("t3_diff1", 1'b0, 3'd1, 10'd0,   -1, -1, 0, '0, -1, 1'b1);
    run_frame("t3_sgl1",  1'b1, 3'd1, 10'd100, -1, -1, 0, '0, -1, 1'b1);

    // 4: ch2 zeroed at S+8 must not disturb the frozen sample
    run_frame("t4", 1'b1, 3'd2, 10'h2A5, -1, 8, 2, 10'h000, -1, 1'b1);
    set_ch(2, 10'h2A5);

    // conv together with a start bit in IDLE: ignored, no error pulse
    din  = 1'b1;
    conv = 1'b1;
    @(negedge clk);
    din  = 1'b0;
    conv = 1'b0;
    chk("idle_conv busy", 32'({busy, frame_err}), 32'(0));
    @(negedge clk);
    chk("idle_conv ferr", 32'({busy, frame_err}), 32'(0));

    // 5: abort at S+10, new start at S+13
    run_frame("t5_abort", 1'b1, 3'd2, 10'h2A5, 10, -1, 0, '0, -1, 1'b0);
    chk("t5 cfg_kept", 32'({cfg_sgl, cfg_ch}), 32'({1'b1, 3'd2}));
    run_frame("t5_after", 1'b1, 3'd2, 10'h2A5, -1, -1, 0, '0, -1, 1'b1);

    // 6: streaming 19-cycle frames
    set_ch(5, 10'd1);
    set_ch(0, 10'd1023);
    set_ch(7, 10'd512);
    run_frame("t6_ch5", 1'b1, 3'd5, 10'd1,    -1, -1, 0, '0, -1, 1'b1);
    run_frame("t6_ch0", 1'b1, 3'd0, 10'd1023, -1, -1, 0, '0, -1, 1'b1);
    run_frame("t6_ch7", 1'b1, 3'd7, 10'd512,  -1, -1, 0, '0, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
